// File: rtl/sensor_sched_pkg.sv
// Shared types and helpers for the sensor sampling scheduler.
package sensor_sched_pkg;

  typedef enum logic [2:0] {StIdle, StArm, StReq, StWrite, StNext} sched_state_t;

  localparam int unsigned MaxCh     = 32;
  localparam int unsigned MaxChIdxW = 5;

  typedef struct packed {
    logic                 found;
    logic [MaxChIdxW-1:0] idx;
  } ch_sel_t;

  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Lowest set bit of mask strictly above index 'after'; pass -1 to search from bit 0.
  function automatic ch_sel_t next_set_bit(input logic [MaxCh-1:0] mask, input int after);
    ch_sel_t sel;
    sel = '0;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (mask[i] && (i > after)) begin
        sel.found = 1'b1;
        sel.idx   = i[MaxChIdxW-1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sensor_sample_sched_timer.sv
// Sample-period down-counter: holds period-1 while disabled, ticks one cycle at zero.
module sensor_period_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] reload;

  // A zero period behaves like a period of one.
  always_comb reload = (period == '0) ? '0 : period - 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (!en) begin
      cnt_q <= reload;
      tick  <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q <= reload;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q - 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/sensor_sample_sched.sv
// Walks enabled sensor channels each period, handshakes, and writes samples to the reg bank.
// Define SENSOR_SCHED_TIMEOUT_EN to add the per-request ack timeout.
module sensor_sample_sched
  import sensor_sched_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PERIOD_W    = 24,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_aresetn,
  input  logic                       enable,
  input  logic [PERIOD_W-1:0]        period,
  input  logic [NUM_CH-1:0]          ch_mask,
  output logic [NUM_CH-1:0]          sens_req,
  input  logic [NUM_CH-1:0]          sens_ack,
  input  logic [NUM_CH*DATA_W-1:0]   sens_data,
  output logic                       wr_en,
  output logic [ch_idx_w(NUM_CH)-1:0] wr_idx,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       busy,
  output logic [15:0]                round_cnt,
  output logic                       overrun,
  output logic [NUM_CH-1:0]          err_timeout,
  input  logic                       err_clr
);

  localparam int unsigned IdxW = ch_idx_w(NUM_CH);

  sched_state_t         state_q;
  logic [MaxChIdxW-1:0] ch_q;
  logic                 tick;
  logic                 in_round;
  logic                 to_hit;
  logic [MaxCh-1:0]     mask_ext;
  ch_sel_t              first_sel;
  ch_sel_t              next_sel;
  logic [NUM_CH-1:0]    first_req;
  logic [NUM_CH-1:0]    next_req;
  logic [DATA_W-1:0]    ack_data;

  sensor_period_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .en    (enable),
    .period(period),
    .tick  (tick)
  );

  // The live mask is consulted at every selection, so mid-round edits reach higher channels.
  always_comb begin
    mask_ext             = '0;
    mask_ext[NUM_CH-1:0] = ch_mask;
    first_sel            = next_set_bit(mask_ext, -1);
    next_sel             = next_set_bit(mask_ext, int'(ch_q));
    first_req            = '0;
    first_req[first_sel.idx[IdxW-1:0]] = 1'b1;
    next_req             = '0;
    next_req[next_sel.idx[IdxW-1:0]]   = 1'b1;
    ack_data             = sens_data[int'(ch_q[IdxW-1:0]) * DATA_W +: DATA_W];
    in_round             = state_q inside {StReq, StWrite, StNext};
  end

`ifdef SENSOR_SCHED_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  logic [ToW-1:0] to_cnt_q;

  assign to_hit = (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn || state_q != StReq) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      sens_req    <= '0;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      round_cnt   <= '0;
      overrun     <= 1'b0;
      err_timeout <= '0;
    end else begin
      wr_en <= 1'b0;
      if (err_clr) begin
        overrun     <= 1'b0;
        err_timeout <= '0;
      end else if (enable && tick && in_round) begin
        overrun <= 1'b1;
      end

      if (!enable) begin
        // Abort: drop any request and discard a pending write without counting the round.
        state_q  <= StIdle;
        sens_req <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StArm;
          StArm: begin
            if (tick) begin
              if (first_sel.found) begin
                ch_q     <= first_sel.idx;
                sens_req <= first_req;
                busy     <= 1'b1;
                state_q  <= StReq;
              end else begin
                round_cnt <= round_cnt + 1'b1;
              end
            end
          end
          StReq: begin
            if (sens_ack[ch_q[IdxW-1:0]]) begin
              sens_req <= '0;
              wr_en    <= 1'b1;
              wr_idx   <= ch_q[IdxW-1:0];
              wr_data  <= ack_data;
              state_q  <= StWrite;
            end else if (to_hit) begin
              sens_req <= '0;
              if (!err_clr) err_timeout[ch_q[IdxW-1:0]] <= 1'b1;
              state_q  <= StNext;
            end
          end
          StWrite: state_q <= StNext;
          StNext: begin
            if (next_sel.found) begin
              ch_q     <= next_sel.idx;
              sens_req <= next_req;
              state_q  <= StReq;
            end else begin
              round_cnt <= round_cnt + 1'b1;
              busy      <= 1'b0;
              state_q   <= StArm;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
